asm_pass_controller: RTL and testbench

//  Sequences the two-pass on-FPGA RISC-V assembler: IDLE -> PC_MAPPING (pass 1, label PCs) -> INSTRUCTION_MAPPING (pass 2, encode + IMEM write) -> SUCCESS/ERROR.

---
 rtl/asm_pass_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_asm_pass_controller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asm_pass_controller.sv
// Two-pass assembler sequencer: pass 1 binds label PCs, pass 2 encodes lines and writes IMEM.
// Optional watchdog on outstanding parser/encoder requests: define ASM_CTRL_TIMEOUT_EN.
module asm_pass_controller #(
  parameter int unsigned IMEM_DEPTH     = 1024,
  parameter int unsigned LINE_W         = 12,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned ADDR_W        = $clog2(IMEM_DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic              line_rewind_out,
  output logic              line_req_out,
  input  logic              line_valid_in,
  input  logic [1:0]        line_kind_in,
  input  logic              line_err_in,
  output logic              label_wr_out,
  output logic [31:0]       label_pc_out,
  input  logic              label_full_in,
  output logic              enc_req_out,
  output logic [31:0]       enc_pc_out,
  input  logic              enc_done_in,
  input  logic              enc_err_in,
  input  logic [31:0]       enc_instr_in,
  output logic              imem_we_out,
  output logic [ADDR_W-1:0] imem_addr_out,
  output logic [31:0]       imem_data_out,
  output logic [2:0]        state_out,
  output logic [2:0]        err_code_out,
  output logic [LINE_W-1:0] err_line_out,
  output logic [ADDR_W:0]   instr_count_out
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPcMap    = 3'd1,
    StInstrMap = 3'd2,
    StError    = 3'd3,
    StSuccess  = 3'd4
  } state_e;

  typedef enum logic [1:0] {PhReq, PhWait, PhEnc} phase_e;

  localparam logic [1:0] KindBlank = 2'b00;
  localparam logic [1:0] KindLabel = 2'b01;
  localparam logic [1:0] KindInstr = 2'b10;
  localparam logic [1:0] KindEof   = 2'b11;

  localparam logic [2:0] ErrNone     = 3'd0;
  localparam logic [2:0] ErrParse    = 3'd1;
  localparam logic [2:0] ErrLblFull  = 3'd2;
  localparam logic [2:0] ErrEncode   = 3'd3;
  localparam logic [2:0] ErrOverflow = 3'd4;
  localparam logic [2:0] ErrCount    = 3'd5;
  localparam logic [2:0] ErrTimeout  = 3'd6;

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(IMEM_DEPTH);

  state_e              state_q;
  phase_e              phase_q;
  logic [31:0]         pc_q;
  logic [LINE_W-1:0]   line_cnt_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     instr_count_q;
  logic [2:0]          err_code_q;
  logic [LINE_W-1:0]   err_line_q;
  logic                line_rewind_q, line_req_q, label_wr_q, enc_req_q, imem_we_q;
  logic [31:0]         label_pc_q, enc_pc_q, imem_data_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic                wd_fire;

`ifdef ASM_CTRL_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic           in_wait, resp;
  logic [WdW-1:0] wd_q;

  assign in_wait = ((state_q == StPcMap) || (state_q == StInstrMap)) && (phase_q != PhReq);
  assign resp    = (phase_q == PhEnc) ? enc_done_in : line_valid_in;

  always_ff @(posedge clk_in) begin
    if (rst_in || !in_wait || resp) wd_q <= '0;
    else                            wd_q <= wd_q + WdW'(1);
  end

  assign wd_fire = in_wait && !resp && (wd_q == WdW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign wd_fire        = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= StIdle;
      phase_q       <= PhReq;
      pc_q          <= '0;
      line_cnt_q    <= '0;
      cnt_q         <= '0;
      instr_count_q <= '0;
      err_code_q    <= ErrNone;
      err_line_q    <= '0;
      line_rewind_q <= 1'b0;
      line_req_q    <= 1'b0;
      label_wr_q    <= 1'b0;
      enc_req_q     <= 1'b0;
      imem_we_q     <= 1'b0;
      label_pc_q    <= '0;
      enc_pc_q      <= '0;
      imem_addr_q   <= '0;
      imem_data_q   <= '0;
    end else begin
      line_rewind_q <= 1'b0;
      line_req_q    <= 1'b0;
      label_wr_q    <= 1'b0;
      enc_req_q     <= 1'b0;
      imem_we_q     <= 1'b0;
      unique case (state_q)
        StIdle, StError, StSuccess: begin
          if (start_in) begin
            state_q       <= StPcMap;
            phase_q       <= PhReq;
            pc_q          <= '0;
            line_cnt_q    <= '0;
            cnt_q         <= '0;
            instr_count_q <= '0;
            err_code_q    <= ErrNone;
            err_line_q    <= '0;
            line_rewind_q <= 1'b1;
          end
        end
        StPcMap: begin
          if (phase_q == PhReq) begin
            line_req_q <= 1'b1;
            phase_q    <= PhWait;
          end else if (line_valid_in) begin
            phase_q <= PhReq;
            if (line_kind_in != KindEof) line_cnt_q <= line_cnt_q + LINE_W'(1);
            if (line_err_in) begin
              state_q    <= StError;
              err_code_q <= ErrParse;
              err_line_q <= line_cnt_q;
            end else begin
              case (line_kind_in)
                KindLabel: begin
                  if (label_full_in) begin
                    state_q    <= StError;
                    err_code_q <= ErrLblFull;
                    err_line_q <= line_cnt_q;
                  end else begin
                    label_wr_q <= 1'b1;
                    label_pc_q <= pc_q;
                  end
                end
                KindInstr: begin
                  if (cnt_q == DepthCnt) begin
                    state_q    <= StError;
                    err_code_q <= ErrOverflow;
                    err_line_q <= line_cnt_q;
                  end else begin
                    pc_q  <= pc_q + 32'd4;
                    cnt_q <= cnt_q + (ADDR_W + 1)'(1);
                  end
                end
                KindEof: begin
                  instr_count_q <= cnt_q;
                  pc_q          <= '0;
                  line_cnt_q    <= '0;
                  line_rewind_q <= 1'b1;
                  state_q       <= StInstrMap;
                end
                default: ;
              endcase
            end
          end
        end
        StInstrMap: begin
          if (phase_q == PhReq) begin
            line_req_q <= 1'b1;
            phase_q    <= PhWait;
          end else if (phase_q == PhWait) begin
            if (line_valid_in) begin
              phase_q <= PhReq;
              if (line_kind_in != KindEof) line_cnt_q <= line_cnt_q + LINE_W'(1);
              if (line_err_in) begin
                state_q    <= StError;
                err_code_q <= ErrParse;
                err_line_q <= line_cnt_q;
              end else if (line_kind_in == KindInstr) begin
                enc_req_q <= 1'b1;
                enc_pc_q  <= pc_q;
                phase_q   <= PhEnc;
              end else if (line_kind_in == KindEof) begin
                // Both passes must agree on how many instructions the program holds.
                if (pc_q[31:2] == 30'(instr_count_q)) begin
                  state_q <= StSuccess;
                end else begin
                  state_q    <= StError;
                  err_code_q <= ErrCount;
                  err_line_q <= line_cnt_q;
                end
              end
            end
          end else if (enc_done_in) begin
            if (enc_err_in) begin
              state_q    <= StError;
              err_code_q <= ErrEncode;
              err_line_q <= line_cnt_q - LINE_W'(1);
            end else begin
              imem_we_q   <= 1'b1;
              imem_addr_q <= pc_q[ADDR_W+1:2];
              imem_data_q <= enc_instr_in;
              pc_q        <= pc_q + 32'd4;
              phase_q     <= PhReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      if (wd_fire) begin
        state_q    <= StError;
        err_code_q <= ErrTimeout;
        err_line_q <= (phase_q == PhEnc) ? line_cnt_q - LINE_W'(1) : line_cnt_q;
      end
    end
  end

  assign line_rewind_out = line_rewind_q;
  assign line_req_out    = line_req_q;
  assign label_wr_out    = label_wr_q;
  assign label_pc_out    = label_pc_q;
  assign enc_req_out     = enc_req_q;
  assign enc_pc_out      = enc_pc_q;
  assign imem_we_out     = imem_we_q;
  assign imem_addr_out   = imem_addr_q;
  assign imem_data_out   = imem_data_q;
  assign state_out       = state_q;
  assign err_code_out    = err_code_q;
  assign err_line_out    = err_line_q;
  assign instr_count_out = instr_count_q;

endmodule

// File: tb/tb_asm_pass_controller.sv
// Scoreboard bench for asm_pass_controller with behavioural parser and encoder responders.
module tb_asm_pass_controller;
  localparam int unsigned Depth = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned LW    = 12;

  typedef logic [20:0] status_t;  // {state, err_code, err_line, instr_count}

  logic          clk = 1'b0;
  logic          rst_in, start_in;
  logic          line_rewind_out, line_req_out, line_valid_in, line_err_in;
  logic [1:0]    line_kind_in;
  logic          label_wr_out, label_full_in;
  logic [31:0]   label_pc_out, enc_pc_out, enc_instr_in, imem_data_out;
  logic          enc_req_out, enc_done_in, enc_err_in, imem_we_out;
  logic [AW-1:0] imem_addr_out;
  logic [2:0]    state_out, err_code_out;
  logic [LW-1:0] err_line_out;
  logic [AW:0]   instr_count_out;

  always #5 clk = ~clk;

  asm_pass_controller #(.IMEM_DEPTH(Depth), .LINE_W(LW), .TIMEOUT_CYCLES(4096)) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .line_rewind_out(line_rewind_out), .line_req_out(line_req_out),
    .line_valid_in(line_valid_in), .line_kind_in(line_kind_in), .line_err_in(line_err_in),
    .label_wr_out(label_wr_out), .label_pc_out(label_pc_out), .label_full_in(label_full_in),
    .enc_req_out(enc_req_out), .enc_pc_out(enc_pc_out), .enc_done_in(enc_done_in),
    .enc_err_in(enc_err_in), .enc_instr_in(enc_instr_in),
    .imem_we_out(imem_we_out), .imem_addr_out(imem_addr_out), .imem_data_out(imem_data_out),
    .state_out(state_out), .err_code_out(err_code_out), .err_line_out(err_line_out),
    .instr_count_out(instr_count_out)
  );

  int total = 0;
  int bad   = 0;
  int rewinds = 0;

  logic [1:0]  prog_kind [16];
  logic [1:0]  prog_kind2 [16];
  logic        prog_perr [16];
  logic        prog_eerr [16];
  logic [31:0] prog_word [16];
  logic        alt_mode = 1'b0;
  logic        parser_stall = 1'b0;
  int          cur_line = 0;

  logic [31:0]   exp_label [$];
  logic [AW+31:0] exp_imem [$];
  status_t       exp_end [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: strobe seen with nothing expected", name);
  endtask

  function automatic status_t mk(input int st, input int code, input int line, input int cnt);
    return {3'(st), 3'(code), 12'(line), 3'(cnt)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      prog_kind[i] = 2'b11; prog_kind2[i] = 2'b11;
      prog_perr[i] = 1'b0;  prog_eerr[i] = 1'b0;
      prog_word[i] = 32'h0;
    end
  endtask

  task automatic set_line(input int i, input logic [1:0] k, input logic [31:0] w,
                          input logic ee, input logic pe);
    prog_kind[i] = k; prog_kind2[i] = k; prog_word[i] = w;
    prog_eerr[i] = ee; prog_perr[i] = pe;
  endtask

  // Parser model: answers each request two cycles later; beyond the program it returns EOF.
  initial begin : parser
    int idx;
    int pend;
    idx = 0; pend = -1;
    line_valid_in = 1'b0; line_kind_in = 2'b00; line_err_in = 1'b0;
    forever begin
      @(negedge clk);
      line_valid_in = 1'b0; line_kind_in = 2'b00; line_err_in = 1'b0;
      if (rst_in) pend = -1;
      if (line_rewind_out) idx = 0;
      if (pend > 0) pend--;
      if (pend == 0) begin
        line_valid_in = 1'b1;
        if (idx < 16) begin
          line_kind_in = (alt_mode && state_out == 3'd2) ? prog_kind2[idx] : prog_kind[idx];
          line_err_in  = prog_perr[idx];
        end else begin
          line_kind_in = 2'b11;
        end
        cur_line = idx;
        idx++;
        pend = -1;
      end
      if (line_req_out && !parser_stall && !rst_in) pend = 2;
    end
  end

  initial begin : encoder
    int pend;
    pend = -1;
    enc_done_in = 1'b0; enc_err_in = 1'b0; enc_instr_in = 32'h0;
    forever begin
      @(negedge clk);
      enc_done_in = 1'b0; enc_err_in = 1'b0; enc_instr_in = 32'h0;
      if (rst_in) pend = -1;
      if (pend > 0) pend--;
      if (pend == 0) begin
        enc_done_in  = 1'b1;
        enc_err_in   = prog_eerr[cur_line];
        enc_instr_in = prog_word[cur_line];
        pend = -1;
      end
      if (enc_req_out && !rst_in) pend = 1;
    end
  end

  initial begin : monitor
    logic [2:0] prev;
    prev = 3'd0;
    forever begin
      @(negedge clk);
      if (line_rewind_out) rewinds++;
      if (label_wr_out) begin
        if (exp_label.size() == 0) unexpected("label_wr");
        else check("label_pc", 64'(label_pc_out), 64'(exp_label.pop_front()));
      end
      if (imem_we_out) begin
        if (exp_imem.size() == 0) unexpected("imem_we");
        else check("imem_wr", 64'({imem_addr_out, imem_data_out}), 64'(exp_imem.pop_front()));
      end
      if (state_out != prev && state_out >= 3'd3) begin
        if (exp_end.size() == 0) unexpected("end_state");
        else check("end_status",
                   64'({state_out, err_code_out, err_line_out, instr_count_out}),
                   64'(exp_end.pop_front()));
      end
      prev = state_out;
    end
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (state_out < 3'd3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (state_out < 3'd3) begin
      total++; bad++;
      $display("FAIL %s_timeout: state=%0d required terminal state", name, state_out);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic drain(input string name, input int base, input int req_rewinds);
    check({name, "_label_q"}, 64'(exp_label.size()), 64'd0);
    check({name, "_imem_q"}, 64'(exp_imem.size()), 64'd0);
    check({name, "_end_q"}, 64'(exp_end.size()), 64'd0);
    check({name, "_rewinds"}, 64'(rewinds - base), 64'(req_rewinds));
  endtask

  task automatic pulse_start();
    @(negedge clk); start_in = 1'b1;
    @(negedge clk); start_in = 1'b0;
  endtask

  task automatic load_basic();
    clear_prog();
    set_line(0, 2'b01, 32'h0, 1'b0, 1'b0);
    set_line(1, 2'b10, 32'h0050_0093, 1'b0, 1'b0);
    set_line(2, 2'b00, 32'h0, 1'b0, 1'b0);
    set_line(3, 2'b10, 32'h0020_8463, 1'b0, 1'b0);
    exp_label.push_back(32'd0);
    exp_imem.push_back({2'd0, 32'h0050_0093});
    exp_imem.push_back({2'd1, 32'h0020_8463});
    exp_end.push_back(mk(4, 0, 0, 2));
  endtask

  initial begin : main
    int base;
    int reqs;
    rst_in = 1'b1; start_in = 1'b0; label_full_in = 1'b0;
    clear_prog();
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    check("rst_state", 64'(state_out), 64'd0);
    check("rst_err", 64'({err_code_out, err_line_out, instr_count_out}), 64'd0);
    check("rst_strobes", 64'({line_rewind_out, line_req_out, label_wr_out, enc_req_out,
                              imem_we_out}), 64'd0);

    // Basic program: label, addi, blank, beq, EOF.
    load_basic();
    base = rewinds; pulse_start(); wait_done("basic"); drain("basic", base, 2);

    // Encode error on the second instruction, which sits at line 5.
    clear_prog();
    set_line(0, 2'b10, 32'h1111_1111, 1'b0, 1'b0);
    set_line(1, 2'b00, 32'h0, 1'b0, 1'b0);
    set_line(2, 2'b01, 32'h0, 1'b0, 1'b0);
    set_line(3, 2'b00, 32'h0, 1'b0, 1'b0);
    set_line(4, 2'b00, 32'h0, 1'b0, 1'b0);
    set_line(5, 2'b10, 32'h2222_2222, 1'b1, 1'b0);
    exp_label.push_back(32'd4);
    exp_imem.push_back({2'd0, 32'h1111_1111});
    exp_end.push_back(mk(3, 3, 5, 2));
    base = rewinds; pulse_start(); wait_done("enc_err"); drain("enc_err", base, 2);

    // Full label table.
    clear_prog();
    set_line(0, 2'b10, 32'h3, 1'b0, 1'b0);
    set_line(1, 2'b01, 32'h0, 1'b0, 1'b0);
    label_full_in = 1'b1;
    exp_end.push_back(mk(3, 2, 1, 0));
    base = rewinds; pulse_start(); wait_done("lbl_full"); drain("lbl_full", base, 1);
    label_full_in = 1'b0;

    // Five instructions into a four-word IMEM.
    clear_prog();
    for (int i = 0; i < 5; i++) set_line(i, 2'b10, 32'(i + 16), 1'b0, 1'b0);
    exp_end.push_back(mk(3, 4, 4, 0));
    base = rewinds; pulse_start(); wait_done("overflow"); drain("overflow", base, 1);

    // Parse error dominates the line kind.
    clear_prog();
    set_line(0, 2'b00, 32'h0, 1'b0, 1'b0);
    set_line(1, 2'b10, 32'h5, 1'b0, 1'b0);
    set_line(2, 2'b10, 32'h6, 1'b0, 1'b1);
    exp_end.push_back(mk(3, 1, 2, 0));
    base = rewinds; pulse_start(); wait_done("parse_err"); drain("parse_err", base, 1);

    // Pass 2 sees one fewer instruction than pass 1.
    clear_prog();
    set_line(0, 2'b10, 32'hA0, 1'b0, 1'b0);
    set_line(1, 2'b10, 32'hA1, 1'b0, 1'b0);
    set_line(2, 2'b10, 32'hA2, 1'b0, 1'b0);
    prog_kind2[1] = 2'b00;
    alt_mode = 1'b1;
    exp_imem.push_back({2'd0, 32'hA0});
    exp_imem.push_back({2'd1, 32'hA2});
    exp_end.push_back(mk(3, 5, 3, 3));
    base = rewinds; pulse_start(); wait_done("mismatch"); drain("mismatch", base, 2);
    alt_mode = 1'b0;

    // Restart from ERROR, with a start pulse mid-pass that must be ignored.
    load_basic();
    base = rewinds;
    @(negedge clk); start_in = 1'b1;
    @(negedge clk); start_in = 1'b0;
    check("restart_rewind", 64'(line_rewind_out), 64'd1);
    check("restart_state", 64'(state_out), 64'd1);
    check("restart_err_clr", 64'(err_code_out), 64'd0);
    @(negedge clk); start_in = 1'b1;
    @(negedge clk); start_in = 1'b0;
    check("midpass_state", 64'(state_out), 64'd1);
    wait_done("restart"); drain("restart", base, 2);

    // Parser stalls for 5000 cycles.
    clear_prog();
    parser_stall = 1'b1;
`ifdef ASM_CTRL_TIMEOUT_EN
    exp_end.push_back(mk(3, 6, 0, 0));
`endif
    pulse_start();
    repeat (5000) @(negedge clk);
`ifdef ASM_CTRL_TIMEOUT_EN
    check("stall_state", 64'(state_out), 64'd3);
`else
    check("stall_state", 64'(state_out), 64'd1);
`endif
    check("stall_end_q", 64'(exp_end.size()), 64'd0);
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    check("midwait_rst_state", 64'(state_out), 64'd0);
    check("midwait_rst_err", 64'({err_code_out, err_line_out, instr_count_out}), 64'd0);
    parser_stall = 1'b0;
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (line_req_out || enc_req_out || line_rewind_out) reqs++;
    end
    check("post_rst_quiet", 64'(reqs), 64'd0);
    check("post_rst_idle", 64'(state_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
